// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default widths, NOP encoding and
// the IF/ID payload layout.
package riscv_pkg;
  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pcplus4;
  } if_id_payload_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;
endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus payload register.
// The payload is only written on load and keeps its last value when cleared.
module pipe_slot #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;
endmodule

// File: rtl/if_id_pipe_reg.sv
// Fetch->decode pipeline register with valid/ready handshake, flush-to-bubble
// and an optional two-entry skid buffer that makes in_ready a flop output.
module if_id_pipe_reg #(
  parameter int              XLEN     = riscv_pkg::XLEN_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSN = XLEN'(riscv_pkg::NOP_INSN),
  parameter bit              SKID     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pcplus4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcplus4
);
  import riscv_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } payload_t;
  localparam int PW = $bits(payload_t);

  occ_state_t state_d, state_q;
  logic       in_xfer, out_xfer;
  logic       main_load, main_clr, main_valid;
  logic       skid_load, skid_clr, skid_valid;
  payload_t   in_pl, main_d, main_q, skid_q;

  assign in_pl    = '{instr: in_instr, pc: in_pc, pcplus4: in_pcplus4};
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_d    = in_pl;
    if (flush) begin
      // decode's handshake this cycle still completes; everything else is dropped
      state_d  = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: if (in_xfer) begin
          main_load = 1'b1;
          state_d   = OCC_ONE;
        end
        OCC_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer && SKID) begin
            skid_load = 1'b1;
            state_d   = OCC_TWO;
          end else if (out_xfer) begin
            main_clr = 1'b1;
            state_d  = OCC_EMPTY;
          end
        end
        OCC_TWO: if (out_xfer && skid_valid) begin
          main_load = 1'b1;
          main_d    = skid_q;
          skid_clr  = 1'b1;
          state_d   = OCC_ONE;
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  pipe_slot #(.W(PW)) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load), .clr(main_clr),
    .d(main_d), .valid(main_valid), .q(main_q)
  );

  generate
    if (SKID) begin : g_skid
      logic in_ready_d, in_ready_q;

      pipe_slot #(.W(PW)) u_skid (
        .clk(clk), .rst_n(rst_n), .load(skid_load), .clr(skid_clr),
        .d(in_pl), .valid(skid_valid), .q(skid_q)
      );

      always_comb in_ready_d = (state_d != OCC_TWO);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_q <= 1'b1;
        else        in_ready_q <= in_ready_d;
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_q     = '0;
      assign in_ready   = ~main_valid | out_ready;
    end
  endgenerate

  assign out_valid   = main_valid;
  assign out_instr   = main_valid ? main_q.instr : NOP_INSN;
  assign out_pc      = main_q.pc;
  assign out_pcplus4 = main_q.pcplus4;
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Drives a 32-bit skid-buffered stage and a 64-bit single-entry stage with the
// same stimulus and compares both against FIFO-queue models.
module tb_if_id_pipe_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [63:0] in_instr, in_pc, in_pcplus4;

  logic        ir0, ov0, ir1, ov1;
  logic [31:0] oi0, op0, op40;
  logic [63:0] oi1, op1, op41;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] instr;
    logic [63:0] pc;
    logic [63:0] pcp4;
  } item_t;

  item_t mq[2][$];

  always #5 clk = ~clk;

  if_id_pipe_reg dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_instr(in_instr[31:0]), .in_pc(in_pc[31:0]), .in_pcplus4(in_pcplus4[31:0]),
    .out_valid(ov0), .out_ready(out_ready), .out_instr(oi0), .out_pc(op0),
    .out_pcplus4(op40)
  );

  if_id_pipe_reg #(.XLEN(64), .SKID(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
    .out_valid(ov1), .out_ready(out_ready), .out_instr(oi1), .out_pc(op1),
    .out_pcplus4(op41)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stage accepts when it is not full; full means 2 entries with the skid
  // buffer, or 1 entry without it unless decode drains this same cycle.
  function automatic logic model_ready(input int k);
    if (k == 0) return mq[0].size() < 2;
    return (mq[1].size() == 0) || out_ready;
  endfunction

  task automatic check_all();
    logic [63:0] mask, exp_i;
    logic [63:0] obs_v, obs_r, obs_i, obs_p, obs_p4;
    for (int k = 0; k < 2; k++) begin
      mask  = (k == 0) ? 64'hFFFF_FFFF : '1;
      obs_v = (k == 0) ? 64'(ov0) : 64'(ov1);
      obs_r = (k == 0) ? 64'(ir0) : 64'(ir1);
      obs_i = (k == 0) ? 64'(oi0) : oi1;
      obs_p = (k == 0) ? 64'(op0) : op1;
      obs_p4 = (k == 0) ? 64'(op40) : op41;
      exp_i = (mq[k].size() != 0) ? (mq[k][0].instr & mask) : 64'h13;
      chk($sformatf("dut%0d.out_valid", k), obs_v, 64'(mq[k].size() != 0));
      chk($sformatf("dut%0d.in_ready", k), obs_r, 64'(model_ready(k)));
      chk($sformatf("dut%0d.out_instr", k), obs_i, exp_i);
      if (mq[k].size() != 0) begin
        chk($sformatf("dut%0d.out_pc", k), obs_p, mq[k][0].pc & mask);
        chk($sformatf("dut%0d.out_pcplus4", k), obs_p4, mq[k][0].pcp4 & mask);
      end
    end
  endtask

  task automatic step(input logic fl, input logic iv, input logic [63:0] ins,
                      input logic [63:0] pc, input logic ordy);
    logic  rdy [2];
    item_t it;
    logic  has;
    @(negedge clk);
    flush = fl; in_valid = iv; in_instr = ins; in_pc = pc; in_pcplus4 = pc + 64'd4;
    out_ready = ordy;
    #1;
    check_all();
    for (int k = 0; k < 2; k++) rdy[k] = model_ready(k);
    it.instr = ins; it.pc = pc; it.pcp4 = pc + 64'd4;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      has = (mq[k].size() != 0);
      if (fl) begin
        mq[k].delete();
      end else begin
        if (has && ordy) void'(mq[k].pop_front());
        if (iv && rdy[k]) mq[k].push_back(it);
      end
    end
  endtask

  task automatic check_reset_vals();
    chk("rst.out_valid0", 64'(ov0), 64'd0);
    chk("rst.in_ready0", 64'(ir0), 64'd1);
    chk("rst.out_instr0", 64'(oi0), 64'h13);
    chk("rst.out_pc0", 64'(op0), 64'd0);
    chk("rst.out_pcplus4_0", 64'(op40), 64'd0);
    chk("rst.out_valid1", 64'(ov1), 64'd0);
    chk("rst.in_ready1", 64'(ir1), 64'd1);
    chk("rst.out_instr1", oi1, 64'h13);
    chk("rst.out_pc1", op1, 64'd0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    mq[0].delete();
    mq[1].delete();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_pcplus4 = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // straight stream, then a three-cycle stall with fetch still offering
    step(0, 1, 64'h0050_0093, 64'h0, 1);
    step(0, 1, 64'h00A0_0113, 64'h4, 1);
    step(0, 1, 64'h0020_81B3, 64'h8, 1);
    step(0, 1, 64'h00C0_0213, 64'hC, 0);
    step(0, 1, 64'h00D0_0293, 64'h10, 0);
    step(0, 1, 64'h00E0_0313, 64'h14, 0);
    step(0, 1, 64'h00F0_0393, 64'h18, 1);
    step(0, 0, 64'h0, 64'h0, 1);
    step(0, 0, 64'h0, 64'h0, 1);
    step(0, 0, 64'h0, 64'h0, 1);

    // fill to two entries, then flush with a new instruction offered
    step(0, 1, 64'h0110_0413, 64'h20, 0);
    step(0, 1, 64'h0120_0493, 64'h24, 0);
    step(1, 1, 64'h0BAD_0513, 64'h28, 0);
    step(0, 0, 64'h0, 64'h0, 0);
    step(0, 1, 64'h0130_0593, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    step(0, 0, 64'h0, 64'h0, 1);
    step(0, 0, 64'h0, 64'h0, 1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      step(($urandom_range(19) == 0), ($urandom_range(3) != 0),
           {$urandom, $urandom}, {$urandom, $urandom[31:2], 2'b00},
           $urandom_range(1) == 1);
    end
    step(0, 0, 64'h0, 64'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
